alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (one-hot 20-bit opcode, two 32-bit operands, 32-bit result) among NUM_REQ requesters, e.g. the integer pipe, the FP issue stage and the load/store address generator.
- Grants one request at a time, round-robin.
- Registers the operands into the ALU and holds them for a programmable number of cycles, so the long ADDF/MULF paths are treated as multicycle.
- Returns the result tagged with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must be at least clog2(NUM_REQ).
- INT_LAT, 1, EXEC cycles for integer ops (all opcode bits except 18 and 19); must be 1 or more.
- FP_LAT, 3, EXEC cycles for ADDF (bit 18) and MULF (bit 19); must be 1 or more.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_op  in  NUM_REQ*20  flattened one-hot opcodes; requester i occupies [20*i+19:20*i].
- req_a  in  NUM_REQ*32  flattened operand 1.
- req_b  in  NUM_REQ*32  flattened operand 2.
- alu_op  out  20  opcode to ALU Op_in.
- alu_in1  out  32  to ALU input1.
- alu_in2  out  32  to ALU input2.
- alu_result  in  32  from ALU out_32.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_W  index of the requester being answered.
- resp_data  out  32  captured ALU result.
- resp_err  out  1  illegal opcode flag (see Optional Feature).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: FSM in IDLE; rr_ptr=0; lat_cnt=0; alu_op, alu_in1, alu_in2 = 0; resp_valid, resp_id, resp_data, resp_err = 0; req_ready=0; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g] is combinational and asserted in the same cycle; the transfer happens on that edge.
  - On the edge: latch alu_op, alu_in1 and alu_in2 from slice g, set resp_id=g, set rr_ptr=(g+1) mod NUM_REQ.
  - Load lat_cnt with FP_LAT-1 if op bit 18 or 19 is set, otherwise INT_LAT-1. Go to EXEC.
  - No request pending: stay in IDLE, alu_op=0 (ALU output is don't-care).
- EXEC:
  - Operand registers are held stable; req_ready=0 for everyone.
  - When lat_cnt is nonzero, decrement it.
  - When lat_cnt is 0: resp_data <= alu_result, resp_valid <= 1, alu_op <= 0, go to RESP.
- RESP:
  - Hold resp_valid, resp_id, resp_data and resp_err stable until resp_ready=1.
  - On that edge: resp_valid <= 0, go to IDLE.
  - No new grant is made in the same cycle; the next grant is possible on the following cycle.
- Latency: accept edge at cycle T gives resp_valid high from cycle T+1+LAT, where LAT is INT_LAT or FP_LAT. With defaults this is T+2 for integer ops and T+4 for FP ops.
- Requester hold rules:
  - A requester must hold req_valid and its payload until it sees req_ready.
  - Deasserting req_valid before grant is permitted; the request is simply not seen.
- Simultaneous requests: exactly one is granted; the others wait without loss.
- Fairness: with all requesters always valid, grants are issued in the order 0, 1, 2, 3, 0, ...
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset asserted mid-operation (EXEC or RESP): the in-flight op is dropped with no response, and all state returns to its reset values immediately (asynchronous).
- resp_ready while resp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined: an opcode that is not exactly one-hot (zero bits or two or more bits set) is still accepted, but no ALU cycle is issued and alu_op stays 0. The FSM goes straight to RESP on the next edge with resp_err=1 and resp_data=0, so resp_valid is high at T+1.
- Undefined: no check is made; the opcode passes to the ALU unchanged, latency is chosen from bits 18/19 only, and resp_err is tied to 0.

Test Plan:
- Integer ADD, single requester: req 0, op=0x00001, a=5, b=7; expect req_ready[0] at T, alu_op=0x00001 at T+1, resp_valid at T+2 with resp_id=0, resp_data=12.
- FP timing, ADDF: req 1, op=0x40000, a=0x3F800000, b=0x3F800000; expect resp_valid at T+4 with resp_data=0x40000000 and alu_in1/alu_in2 stable throughout EXEC.
- Round robin, all four valid with SUB (op=0x00002), a=10*i, b=i, resp_ready=1: expect grant order 0, 1, 2, 3, 0 and resp_data values 0, 9, 18, 27.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid; expect resp_data to be held, no new req_ready while req 2 waits, and req 2 granted exactly one cycle after the resp_ready edge.
- Reset in EXEC: drop rst_n during the MULF EXEC; expect all outputs to be 0 asynchronously, no response after release, and the next grant search to start at req 0.
- ALU_OP_CHECK_EN: op=0x00003; expect resp_valid at T+1 with resp_err=1, resp_data=0, and alu_op never nonzero. Without the macro: resp_err=0 and the result comes from the ALU.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters, with multicycle hold.
// Optional macro ALU_OP_CHECK_EN: reject non-one-hot opcodes with resp_err instead of issuing them.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned INT_LAT = 1,
    parameter int unsigned FP_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*20-1:0] req_op,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [19:0]           alu_op,
    output logic [31:0]           alu_in1,
    output logic [31:0]           alu_in2,
    input  logic [31:0]           alu_result,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int unsigned MaxLat = (INT_LAT > FP_LAT) ? INT_LAT : FP_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam int unsigned PtrW   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [19:0]       alu_op_q, alu_op_d;
    logic [31:0]       in1_q, in1_d;
    logic [31:0]       in2_q, in2_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic              gnt_found;
    logic [PtrW-1:0]   gnt_idx;
    int unsigned       cand;
    logic [19:0]       gnt_op;
    logic              gnt_fp;
    logic              op_legal;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = (32'(rr_ptr_q) + 32'(k)) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = PtrW'(cand);
            end
        end
    end

    assign gnt_op = req_op[20*gnt_idx +: 20];
    assign gnt_fp = gnt_op[18] | gnt_op[19];

`ifdef ALU_OP_CHECK_EN
    assign op_legal = (gnt_op != '0) && ((gnt_op & (gnt_op - 20'd1)) == '0);
`else
    assign op_legal = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lat_cnt_d    = lat_cnt_q;
        alu_op_d     = alu_op_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;
        case (state_q)
            StIdle: begin
                alu_op_d = '0;
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    in1_d     = req_a[32*gnt_idx +: 32];
                    in2_d     = req_b[32*gnt_idx +: 32];
                    resp_id_d = ID_W'(gnt_idx);
                    rr_ptr_d  = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    if (op_legal) begin
                        alu_op_d   = gnt_op;
                        lat_cnt_d  = gnt_fp ? CntW'(FP_LAT - 1) : CntW'(INT_LAT - 1);
                        resp_err_d = 1'b0;
                        state_d    = StExec;
                    end else begin
                        // Illegal opcode: skip the ALU entirely and answer next cycle.
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_err_d   = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StExec: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else begin
                    resp_data_d  = alu_result;
                    resp_valid_d = 1'b1;
                    alu_op_d     = '0;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            lat_cnt_q    <= '0;
            alu_op_q     <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_cnt_q    <= lat_cnt_d;
            alu_op_q     <= alu_op_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != StIdle);

endmodule
